controlador_display_multi: RTL

CONTROLADOR_DISPLAY_MULTI -- requirements
Module: controlador_display_multi

---
 rtl/controlador_display_multi.sv | 131 +++++++++++++
 1 files changed

// File: rtl/controlador_display_multi.sv
// Multiplexed 7-segment display controller: digit scan, PWM brightness per slot,
// leading-zero blanking and frame-synchronous double-buffered data loading.
module controlador_display_multi #(
    parameter int N_DIGITS       = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_n,
    input  logic [4*N_DIGITS-1:0] i_Datos,
    input  logic [N_DIGITS-1:0]   i_Punto,
    input  logic                  i_Cargar,
    input  logic                  i_Blank_Ceros,
    input  logic [3:0]            i_Brillo,
    output logic [N_DIGITS-1:0]   o_Anodo,
    output logic [6:0]            o_Segmentos,
    output logic                  o_Punto,
    output logic                  o_Ocupado
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = $clog2(N_DIGITS);
    localparam logic [PW-1:0]       PRESC_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0]       IDX_MAX   = IW'(N_DIGITS - 1);
    localparam logic [6:0]          SEG_OFF   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [N_DIGITS-1:0] AN_OFF    = AN_ACTIVE_LOW ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};
    localparam logic [N_DIGITS-1:0] AN_ONE    = {{(N_DIGITS-1){1'b0}}, 1'b1};

    logic [PW-1:0]         r_Presc;
    logic [3:0]            r_Sub;
    logic [IW-1:0]         r_Idx;
    logic [4*N_DIGITS-1:0] r_Disp;
    logic [4*N_DIGITS-1:0] r_Pend;
    logic [N_DIGITS-1:0]   r_DpDisp;
    logic [N_DIGITS-1:0]   r_DpPend;
    logic                  r_Ocupado;
    logic [N_DIGITS-1:0]   r_Anodo;
    logic [6:0]            r_Seg;
    logic                  r_Punto;

    logic                  w_Tick;
    logic                  w_Frame;
    logic                  w_Swap;
    logic [3:0]            w_Nibble;
    logic [N_DIGITS-1:0]   w_Lead;
    logic                  w_Blank;
    logic [6:0]            w_SegRaw;
    logic [N_DIGITS-1:0]   w_AnRaw;

    function automatic logic [6:0] f_Hex7(input logic [3:0] v);
        case (v)
            4'h0: f_Hex7 = 7'b0111111;
            4'h1: f_Hex7 = 7'b0000110;
            4'h2: f_Hex7 = 7'b1011011;
            4'h3: f_Hex7 = 7'b1001111;
            4'h4: f_Hex7 = 7'b1100110;
            4'h5: f_Hex7 = 7'b1101101;
            4'h6: f_Hex7 = 7'b1111101;
            4'h7: f_Hex7 = 7'b0000111;
            4'h8: f_Hex7 = 7'b1111111;
            4'h9: f_Hex7 = 7'b1101111;
            4'hA: f_Hex7 = 7'b1110111;
            4'hB: f_Hex7 = 7'b1111100;
            4'hC: f_Hex7 = 7'b0111001;
            4'hD: f_Hex7 = 7'b1011110;
            4'hE: f_Hex7 = 7'b1111001;
            default: f_Hex7 = 7'b1110001;
        endcase
    endfunction

    assign w_Tick  = (r_Presc == PRESC_MAX);
    assign w_Frame = w_Tick && (r_Sub == 4'hF) && (r_Idx == IDX_MAX);
    assign w_Swap  = w_Frame && r_Ocupado;

    // A digit is a leading zero when it and every digit above it hold 0.
    for (genvar g = 0; g < N_DIGITS; g++) begin : g_lead
        assign w_Lead[g] = (r_Disp[4*N_DIGITS-1:4*g] == '0);
    end

    assign w_Nibble = r_Disp[{r_Idx, 2'b00} +: 4];
    assign w_Blank  = i_Blank_Ceros && (r_Idx != '0) && w_Lead[r_Idx];
    assign w_SegRaw = w_Blank ? 7'h00 : f_Hex7(w_Nibble);
    assign w_AnRaw  = (r_Sub < i_Brillo) ? (AN_ONE << r_Idx) : '0;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_Presc   <= '0;
            r_Sub     <= '0;
            r_Idx     <= '0;
            r_Disp    <= '0;
            r_Pend    <= '0;
            r_DpDisp  <= '0;
            r_DpPend  <= '0;
            r_Ocupado <= 1'b0;
            r_Anodo   <= AN_OFF;
            r_Seg     <= SEG_OFF;
            r_Punto   <= SEG_ACTIVE_LOW;
        end else begin
            r_Presc <= w_Tick ? '0 : r_Presc + 1'b1;
            if (w_Tick) begin
                r_Sub <= r_Sub + 4'd1;
                if (r_Sub == 4'hF)
                    r_Idx <= (r_Idx == IDX_MAX) ? '0 : r_Idx + 1'b1;
            end

            // Transfer uses the pre-edge pending value, so a coincident load is kept for the next frame.
            if (w_Swap) begin
                r_Disp   <= r_Pend;
                r_DpDisp <= r_DpPend;
            end
            if (i_Cargar) begin
                r_Pend    <= i_Datos;
                r_DpPend  <= i_Punto;
                r_Ocupado <= 1'b1;
            end else if (w_Swap) begin
                r_Ocupado <= 1'b0;
            end

            r_Anodo <= AN_ACTIVE_LOW ? ~w_AnRaw : w_AnRaw;
            r_Seg   <= SEG_ACTIVE_LOW ? ~w_SegRaw : w_SegRaw;
            r_Punto <= SEG_ACTIVE_LOW ? ~r_DpDisp[r_Idx] : r_DpDisp[r_Idx];
        end
    end

    assign o_Anodo     = r_Anodo;
    assign o_Segmentos = r_Seg;
    assign o_Punto     = r_Punto;
    assign o_Ocupado   = r_Ocupado;

endmodule
